// File: rtl/lusdos_nios_led_pio.sv
// rtl/lusdos_nios_led_pio.sv - Avalon-MM LED output PIO with atomic set/clear and blink engine
module lusdos_nios_led_pio #(
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    PERIOD_WIDTH = 24,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_MASK     = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_STATUS   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    localparam logic [PERIOD_WIDTH-1:0] PERIOD_ONE = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0]   data_reg;
    logic [DATA_WIDTH-1:0]   mask_reg;
    logic [PERIOD_WIDTH-1:0] period_reg;
    logic [PERIOD_WIDTH-1:0] counter;
    logic                    phase;

    logic                    wr_en;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    blink_active;
    logic                    terminal;
    logic [31:0]             rd_mux;
    logic                    unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign wdata        = writedata[DATA_WIDTH-1:0];
    assign blink_active = (period_reg != '0) && (mask_reg != '0);
    assign terminal     = (counter == period_reg - PERIOD_ONE);
    assign unused_wdata = ^writedata[31:PERIOD_WIDTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg   <= RESET_VALUE;
            mask_reg   <= '0;
            period_reg <= '0;
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:     data_reg   <= wdata;
                ADDR_MASK:     mask_reg   <= wdata;
                ADDR_PERIOD:   period_reg <= writedata[PERIOD_WIDTH-1:0];
                ADDR_OUTSET:   data_reg   <= data_reg | wdata;
                ADDR_OUTCLEAR: data_reg   <= data_reg & ~wdata;
                default:       ;
            endcase
        end
    end

    // A PERIOD write always restarts the interval, even on a terminal-count edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter <= '0;
            phase   <= 1'b0;
        end else if (wr_en && address == ADDR_PERIOD) begin
            counter <= '0;
            phase   <= 1'b0;
        end else if (period_reg == '0) begin
            counter <= '0;
            phase   <= 1'b0;
        end else if (terminal) begin
            counter <= '0;
            phase   <= ~phase;
        end else begin
            counter <= counter + PERIOD_ONE;
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        case (address)
            ADDR_DATA:   rd_mux = 32'(data_reg);
            ADDR_MASK:   rd_mux = 32'(mask_reg);
            ADDR_PERIOD: rd_mux = 32'(period_reg);
            ADDR_STATUS: rd_mux = {30'd0, blink_active, phase};
            default:     rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= 32'd0;
            out_port <= RESET_VALUE;
        end else begin
            readdata <= rd_mux;
            out_port <= data_reg ^ (mask_reg & {DATA_WIDTH{phase}});
        end
    end

endmodule
